wbc_arb2: RTL and testbench

//   Two-master Wishbone arbiter and bus watchdog for the shared system bus.
//   It sits between two masters (m0 = vm1_wb CPU, m1 = DMA/debug master) and
//   the single slave-side bus that feeds the address decoder and data mux.
//   - Issues registered, mutually exclusive grants and routes the granted

---
 rtl/wbc_arb2.sv | 146 ++++++++++++++
 tb/tb_wbc_arb2.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wbc_arb2.sv
// Two-master Wishbone arbiter with registered exclusive grants and a bus watchdog that
// terminates unacknowledged strobes with a one-cycle error to the owning master.
module wbc_arb2 #(
  parameter int unsigned TMO   = 64,
  parameter int unsigned TMO_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_sel_i,
  input  logic [15:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic        m0_gnt_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [15:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic [15:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic        m1_gnt_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [15:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [1:0]  s_sel_o,
  output logic [15:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [15:0] s_dat_i,

  output logic        tmo_o
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic               terminal;
  logic               err_fire;

  assign m0_gnt_o = (state_q == StOwn0);
  assign m1_gnt_o = (state_q == StOwn1);

  // Bus routing: only the owner reaches the slave side, everything else reads as 0.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 2'b00;
    s_adr_o = 16'h0000;
    s_dat_o = 16'h0000;
    if (m0_gnt_o) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (m1_gnt_o) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = s_ack_i & m0_gnt_o & m0_stb_i;
  assign m1_ack_o = s_ack_i & m1_gnt_o & m1_stb_i;

  // A same-cycle ack beats the terminal count; reset discards a pending error.
  assign terminal = s_stb_o & ~s_ack_i & (cnt_q == TMO_W'(TMO - 1));
  assign err_fire = terminal & ~wb_rst_i;
  assign m0_err_o = err_fire & m0_gnt_o;
  assign m1_err_o = err_fire & m1_gnt_o;

  assign tmo_o = tmo_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_cyc_i) begin
          state_d = StOwn0;
        end else if (m1_cyc_i) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_cyc_i) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      StOwn1: begin
        if (!m1_cyc_i) begin
          state_d = StIdle;
          last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!s_stb_o || s_ack_i || terminal) begin
      cnt_d = '0;
    end
    tmo_d = tmo_q | terminal;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_wbc_arb2.sv
// Bench for wbc_arb2: directed scenarios with literal checks, then randomized masters and
// slave, all checked every cycle against a transaction-level ownership/watchdog model.
module tb_wbc_arb2;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc_v, stb_v, we_v;
  logic [1:0]  sel [2];
  logic [15:0] adr [2];
  logic [15:0] dat [2];
  logic        ack_r;
  logic [15:0] s_dat;

  logic        g0, g1, a0, a1, e0, e1, tmo;
  logic [15:0] d0, d1;
  logic        s_cyc, s_stb, s_we;
  logic [1:0]  s_sel;
  logic [15:0] s_adr, s_dout;

  always #5 clk = ~clk;

  wbc_arb2 #(.TMO(TMO), .TMO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(cyc_v[0]), .m0_stb_i(stb_v[0]), .m0_we_i(we_v[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_gnt_o(g0), .m0_ack_o(a0), .m0_err_o(e0),
    .m0_dat_o(d0),
    .m1_cyc_i(cyc_v[1]), .m1_stb_i(stb_v[1]), .m1_we_i(we_v[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_gnt_o(g1), .m1_ack_o(a1), .m1_err_o(e1),
    .m1_dat_o(d1),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_dout), .s_ack_i(ack_r), .s_dat_i(s_dat),
    .tmo_o(tmo)
  );

  // Model: who owns the bus, who went last, how many strobe cycles have elapsed unanswered.
  int own, last, age, cyc_no;
  bit tmo_m, auto_slave;
  bit [1:0] ack_seen, err_seen;
  int n_cmp = 0, n_bad = 0;

  logic s_g0, s_g1, s_a0, s_a1, s_e0, s_e1, s_tmo, s_scyc;
  logic [15:0] s_d1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic cycle(input bit do_chk);
    bit sstb_e;
    bit [1:0] ack_e, err_e;
    logic [15:0] sadr_e, sdat_e;
    logic [1:0] ssel_e;
    logic swe_e;
    sstb_e = 1'b0; sadr_e = '0; sdat_e = '0; ssel_e = '0; swe_e = 1'b0;
    if (own >= 0) begin
      sstb_e = stb_v[own]; swe_e = we_v[own]; ssel_e = sel[own];
      sadr_e = adr[own];   sdat_e = dat[own];
    end
    if (auto_slave) begin
      ack_r = 1'b0;
      if (sstb_e) begin
        if (sadr_e != 16'hE000) ack_r = ($urandom_range(0, 2) == 0);
        else if (age + 1 == TMO) ack_r = 1'($urandom_range(0, 1));
      end
      s_dat = 16'($urandom);
    end
    for (int n = 0; n < 2; n++) begin
      ack_e[n] = ack_r && own == n && stb_v[n];
      err_e[n] = own == n && sstb_e && !ack_r && (age + 1 == TMO) && !rst;
    end
    @(negedge clk);
    if (do_chk) begin
      chk("gnt0", 32'(g0), 32'(own == 0));
      chk("gnt1", 32'(g1), 32'(own == 1));
      chk("ack0", 32'(a0), 32'(ack_e[0]));
      chk("ack1", 32'(a1), 32'(ack_e[1]));
      chk("err0", 32'(e0), 32'(err_e[0]));
      chk("err1", 32'(e1), 32'(err_e[1]));
      chk("tmo", 32'(tmo), 32'(tmo_m));
      chk("s_cyc", 32'(s_cyc), 32'(own >= 0 && cyc_v[own]));
      chk("s_stb", 32'(s_stb), 32'(sstb_e));
      chk("s_we", 32'(s_we), 32'(swe_e));
      chk("s_sel", 32'(s_sel), 32'(ssel_e));
      chk("s_adr", 32'(s_adr), 32'(sadr_e));
      chk("s_dat", 32'(s_dout), 32'(sdat_e));
      chk("m0_dat", 32'(d0), 32'(s_dat));
      chk("m1_dat", 32'(d1), 32'(s_dat));
    end
    s_g0 = g0; s_g1 = g1; s_a0 = a0; s_a1 = a1; s_e0 = e0; s_e1 = e1;
    s_tmo = tmo; s_scyc = s_cyc; s_d1 = d1;
    ack_seen = ack_e; err_seen = err_e;
    @(posedge clk);
    if (rst) begin
      own = -1; last = 1; age = 0; tmo_m = 1'b0;
    end else begin
      if (err_e != 0) tmo_m = 1'b1;
      age = (sstb_e && !ack_r && err_e == 0) ? age + 1 : 0;
      if (own < 0) begin
        if (cyc_v[0] && cyc_v[1]) own = (last == 1) ? 0 : 1;
        else if (cyc_v[0]) own = 0;
        else if (cyc_v[1]) own = 1;
      end else if (!cyc_v[own]) begin
        last = own; own = -1;
      end
    end
    cyc_no++;
    #1;
  endtask

  task automatic new_xfer(input int n);
    stb_v[n] = 1'b1;
    we_v[n]  = 1'($urandom);
    sel[n]   = 2'($urandom);
    adr[n]   = ($urandom_range(0, 7) == 0) ? 16'hE000 : 16'($urandom);
    dat[n]   = 16'($urandom);
  endtask

  task automatic drive_masters();
    rst = ($urandom_range(0, 299) == 0);
    for (int n = 0; n < 2; n++) begin
      if (!cyc_v[n]) begin
        if ($urandom_range(0, 3) == 0) begin
          cyc_v[n] = 1'b1;
          new_xfer(n);
        end
      end else if (ack_seen[n] || err_seen[n]) begin
        if ($urandom_range(0, 1) == 1) begin
          cyc_v[n] = 1'b0; stb_v[n] = 1'b0;
        end else begin
          new_xfer(n);
        end
      end else if (own != n && $urandom_range(0, 15) == 0) begin
        cyc_v[n] = 1'b0; stb_v[n] = 1'b0;
      end
    end
  endtask

  initial begin
    own = -1; last = 1; age = 0; tmo_m = 1'b0; cyc_no = 0; auto_slave = 1'b0;
    rst = 1'b1; cyc_v = '0; stb_v = '0; we_v = '0; ack_r = 1'b0; s_dat = '0;
    for (int n = 0; n < 2; n++) begin sel[n] = '0; adr[n] = '0; dat[n] = '0; end
    cycle(1'b0);

    // Reset held with both requesting, m0 wins right after release.
    cyc_v = 2'b11;
    repeat (2) begin
      cycle(1'b1);
      chk("rst_gnt0", 32'(s_g0), 0); chk("rst_gnt1", 32'(s_g1), 0);
      chk("rst_scyc", 32'(s_scyc), 0);
    end
    rst = 1'b0;
    cycle(1'b1);
    cycle(1'b1); chk("first_gnt0", 32'(s_g0), 1); chk("first_gnt1", 32'(s_g1), 0);
    cyc_v = 2'b00;
    repeat (2) cycle(1'b1);

    // m1 single read at 0o001000, slave acks on the third strobe cycle.
    cyc_v = 2'b10; stb_v = 2'b10; adr[1] = 16'h0200; we_v = 2'b00;
    cycle(1'b1); chk("single_pre_gnt", 32'(s_g1), 0);
    cycle(1'b1); chk("single_gnt", 32'(s_g1), 1); chk("single_ack_c1", 32'(s_a1), 0);
    cycle(1'b1); chk("single_ack_c2", 32'(s_a1), 0);
    ack_r = 1'b1; s_dat = 16'h1234;
    cycle(1'b1);
    chk("single_ack", 32'(s_a1), 1); chk("single_dat", 32'(s_d1), 32'h1234);
    chk("single_ack0", 32'(s_a0), 0);
    ack_r = 1'b0; cyc_v = 2'b00; stb_v = 2'b00;
    repeat (2) cycle(1'b1);

    // Timeout to 0o160000: error exactly in the 64th strobe cycle.
    cyc_v = 2'b01; stb_v = 2'b01; adr[0] = 16'hE000;
    cycle(1'b1);
    for (int i = 1; i <= TMO; i++) begin
      cycle(1'b1);
      chk("tmo_err0", 32'(s_e0), 32'(i == TMO));
      chk("tmo_ack0", 32'(s_a0), 0);
    end
    cyc_v = 2'b00; stb_v = 2'b00;
    cycle(1'b1); chk("tmo_sticky", 32'(s_tmo), 1);
    cycle(1'b1);

    // Same, but the ack lands on the terminal cycle and wins.
    cyc_v = 2'b01; stb_v = 2'b01;
    cycle(1'b1);
    repeat (TMO - 1) cycle(1'b1);
    ack_r = 1'b1;
    cycle(1'b1); chk("late_ack0", 32'(s_a0), 1); chk("late_err0", 32'(s_e0), 0);
    ack_r = 1'b0; cyc_v = 2'b00; stb_v = 2'b00;
    repeat (2) cycle(1'b1);

    // Simultaneous request after m0 went last: m1 wins, then m0 after one idle clock.
    cyc_v = 2'b11;
    cycle(1'b1);
    cycle(1'b1); chk("alt_gnt1", 32'(s_g1), 1); chk("alt_gnt0", 32'(s_g0), 0);
    cyc_v = 2'b01;
    cycle(1'b1);
    cycle(1'b1); chk("alt_idle0", 32'(s_g0), 0); chk("alt_idle1", 32'(s_g1), 0);
    cycle(1'b1); chk("alt_next0", 32'(s_g0), 1);
    cyc_v = 2'b00;
    repeat (2) cycle(1'b1);

    // Reset mid-ownership with a strobe pending 30 cycles; watchdog restarts afterwards.
    cyc_v = 2'b10; stb_v = 2'b10; adr[1] = 16'hE000;
    cycle(1'b1);
    repeat (30) cycle(1'b1);
    rst = 1'b1;
    cycle(1'b1); chk("mid_rst_err1", 32'(s_e1), 0);
    rst = 1'b0;
    cycle(1'b1); chk("mid_rst_gnt1", 32'(s_g1), 0);
    for (int i = 1; i <= TMO; i++) begin
      cycle(1'b1);
      chk("restart_err1", 32'(s_e1), 32'(i == TMO));
    end
    cyc_v = 2'b00; stb_v = 2'b00;
    repeat (2) cycle(1'b1);

    // Randomized traffic against the model.
    auto_slave = 1'b1;
    repeat (6000) begin
      cycle(1'b1);
      drive_masters();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
